// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_arbiter
// Brief    : Shared data-memory arbiter and word array behind the cores' M
//            stage. Serves at most one LD/ST per cycle and returns a one-cycle
//            ready_M pulse (plus registered load data) to the served core.
// Options  : MEM_ARB_ROUND_ROBIN_EN - defined: round-robin arbitration;
//            undefined: fixed priority (lowest eligible index wins).
// Revision : 1.0 - initial release
// ============================================================================
module core_mem_arbiter #(
    parameter int CORES_NUM    = 4,
    parameter int REG_SIZE     = 8,
    parameter int CORE_ID_SIZE = 2,
    parameter int ADDR_SIZE    = REG_SIZE + CORE_ID_SIZE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2*CORES_NUM-1:0]        enable_M,
    input  logic [CORES_NUM*ADDR_SIZE-1:0] addr_M,
    input  logic [CORES_NUM*REG_SIZE-1:0] wr_data_M,
    output logic [CORES_NUM*REG_SIZE-1:0] rd_data_M,
    output logic [CORES_NUM-1:0]          ready_M,
    output logic                          grant_valid,
    output logic [CORE_ID_SIZE-1:0]       grant_id
);

    localparam int         c_DEPTH = 2 ** ADDR_SIZE;
    localparam logic [1:0] c_OP_LD = 2'b01;
    localparam logic [1:0] c_OP_ST = 2'b10;

    // Word array; deliberately not cleared by reset.
    logic [REG_SIZE-1:0]     r_mem [c_DEPTH];

    // The registered ready doubles as the ack-pending mask: a core acked this
    // cycle is still presenting the request it just had served.
    logic [CORES_NUM-1:0]    r_ready;
    logic                    r_grant_valid;
    logic [CORE_ID_SIZE-1:0] r_grant_id;

    logic [CORES_NUM-1:0]    w_eligible;
    logic [CORES_NUM-1:0]    w_ready_next;
    logic                    w_grant;
    logic [CORE_ID_SIZE-1:0] w_win_id;
    logic [1:0]              w_win_op;
    logic [ADDR_SIZE-1:0]    w_win_addr;
    logic [REG_SIZE-1:0]     w_win_wdata;
    logic [REG_SIZE-1:0]     w_rd_word;

    genvar gi;

    // Per-core eligibility, one-hot ready and load-data register.
    generate
        for (gi = 0; gi < CORES_NUM; gi++) begin : g_core
            logic [REG_SIZE-1:0] r_word;

            assign w_eligible[gi]   = ((enable_M[2*gi +: 2] == c_OP_LD) ||
                                       (enable_M[2*gi +: 2] == c_OP_ST)) && !r_ready[gi];
            assign w_ready_next[gi] = w_grant && (w_win_id == CORE_ID_SIZE'(gi));
            assign rd_data_M[gi*REG_SIZE +: REG_SIZE] = r_word;

            // Capture array data only for a load served to this core.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_word <= '0;
                end else if (w_ready_next[gi] && (w_win_op == c_OP_LD)) begin
                    r_word <= w_rd_word;
                end
            end
        end
    endgenerate

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [CORE_ID_SIZE-1:0] r_rr_ptr;

    // Round-robin pick: scan the wrapped order backwards so the slot closest
    // to the pointer is assigned last and therefore wins.
    always_comb begin
        int v;
        v           = 0;
        w_grant     = 1'b0;
        w_win_id    = '0;
        w_win_op    = 2'b00;
        w_win_addr  = '0;
        w_win_wdata = '0;
        for (int k = CORES_NUM - 1; k >= 0; k--) begin
            v = int'(r_rr_ptr) + k;
            if (v >= CORES_NUM) v = v - CORES_NUM;
            if (w_eligible[v]) begin
                w_grant     = 1'b1;
                w_win_id    = CORE_ID_SIZE'(v);
                w_win_op    = enable_M[2*v +: 2];
                w_win_addr  = addr_M[v*ADDR_SIZE +: ADDR_SIZE];
                w_win_wdata = wr_data_M[v*REG_SIZE +: REG_SIZE];
            end
        end
    end

    // Pointer moves just past the winner; idle cycles leave it alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= (w_win_id == CORE_ID_SIZE'(CORES_NUM - 1)) ? '0 : w_win_id + 1'b1;
        end
    end
`else
    // Fixed priority pick: scan high to low so the lowest eligible index wins.
    always_comb begin
        w_grant     = 1'b0;
        w_win_id    = '0;
        w_win_op    = 2'b00;
        w_win_addr  = '0;
        w_win_wdata = '0;
        for (int i = CORES_NUM - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_grant     = 1'b1;
                w_win_id    = CORE_ID_SIZE'(i);
                w_win_op    = enable_M[2*i +: 2];
                w_win_addr  = addr_M[i*ADDR_SIZE +: ADDR_SIZE];
                w_win_wdata = wr_data_M[i*REG_SIZE +: REG_SIZE];
            end
        end
    end
`endif

    // Asynchronous array read so a store committed last edge is visible now.
    assign w_rd_word = r_mem[w_win_addr];

    // Commit the winning store; a store in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset && w_grant && (w_win_op == c_OP_ST)) begin
            r_mem[w_win_addr] <= w_win_wdata;
        end
    end

    // Completion pulse and grant debug outputs, one cycle after the grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ready       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
        end else begin
            r_ready       <= w_ready_next;
            r_grant_valid <= w_grant;
            if (w_grant) r_grant_id <= w_win_id;
        end
    end

    assign ready_M     = r_ready;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_mem_arbiter
// Brief    : Self-checking bench for core_mem_arbiter. A transaction-level
//            model predicts outputs every cycle; directed sections add literal
//            expectations for timing, ordering and data.
// Options  : honours MEM_ARB_ROUND_ROBIN_EN for expected grant order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_mem_arbiter;

    localparam int N = 4;
    localparam logic [1:0] c_IDLE = 2'b00, c_LD = 2'b01, c_ST = 2'b10, c_BAD = 2'b11;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit         c_RR       = 1'b1;
    localparam logic [15:0] c_CONT_SEQ = 16'hE4E4;  // 0,1,2,3,0,1,2,3
`else
    localparam bit         c_RR       = 1'b0;
    localparam logic [15:0] c_CONT_SEQ = 16'h4444;  // 0,1,0,1,...
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  enable_M;
    logic [39:0] addr_M;
    logic [31:0] wr_data_M;
    logic [31:0] rd_data_M;
    logic [3:0]  ready_M;
    logic        grant_valid;
    logic [1:0]  grant_id;

    int n_pass;
    int n_total;

    core_mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .enable_M   (enable_M),
        .addr_M     (addr_M),
        .wr_data_M  (wr_data_M),
        .rd_data_M  (rd_data_M),
        .ready_M    (ready_M),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    logic [7:0] m_mem   [1024];
    bit         m_known [1024];
    logic [3:0] e_ready;
    logic [7:0] e_rd    [N];
    bit         e_rd_ok [N];
    bit         e_gv;
    int         e_gid;
    int         m_ptr;
    bit         m_valid;

    initial begin
        m_valid = 1'b0;
        for (int a = 0; a < 1024; a++) m_known[a] = 1'b0;
    end

    always @(posedge clk) begin
        int win, c, op, a;
        if (!reset) begin
            e_ready = 4'b0; e_gv = 1'b0; e_gid = 0; m_ptr = 0;
            for (int i = 0; i < N; i++) begin e_rd[i] = 8'h00; e_rd_ok[i] = 1'b1; end
        end else begin
            win = -1;
            for (int k = 0; k < N; k++) begin
                c  = c_RR ? (m_ptr + k) % N : k;
                op = int'(enable_M[2*c +: 2]);
                if (win < 0 && (op == 1 || op == 2) && !e_ready[c]) win = c;
            end
            e_gv    = (win >= 0);
            e_ready = 4'b0;
            if (win >= 0) begin
                op = int'(enable_M[2*win +: 2]);
                a  = int'(addr_M[10*win +: 10]);
                if (op == 1) begin
                    e_rd[win]    = m_mem[a];
                    e_rd_ok[win] = m_known[a];
                end else begin
                    m_mem[a]   = wr_data_M[8*win +: 8];
                    m_known[a] = 1'b1;
                end
                e_ready[win] = 1'b1;
                e_gid        = win;
                m_ptr        = (win + 1) % N;
            end
        end
        m_valid = 1'b1;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_ready", ready_M, e_ready);
            check("model_gvalid", grant_valid, e_gv);
            if (e_gv) check("model_gid", grant_id, e_gid[1:0]);
            for (int i = 0; i < N; i++)
                if (e_rd_ok[i]) check("model_rd", rd_data_M[8*i +: 8], e_rd[i]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic [1:0] op, input logic [9:0] a, input logic [7:0] d);
        enable_M[2*c +: 2]   = op;
        addr_M[10*c +: 10]   = a;
        wr_data_M[8*c +: 8]  = d;
    endtask

    task automatic do_txn(input int c, input logic [1:0] op, input logic [9:0] a, input logic [7:0] d);
        cyc(); set_req(c, op, a, d);
        cyc();
        cyc(); set_req(c, c_IDLE, 10'h0, 8'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq;
        logic [7:0]  seq4;
        n_pass = 0; n_total = 0;
        reset = 1'b0; enable_M = '0; addr_M = '0; wr_data_M = '0;

        // Reset state
        repeat (3) cyc();
        @(negedge clk);
        check("rst_state", {rd_data_M, ready_M, grant_valid, grant_id}, 39'h0);
        cyc(); reset = 1'b1;

        // Single core ST then LD, one-cycle latency, no double service
        cyc(); set_req(0, c_ST, 10'h013, 8'h5A);
        @(negedge clk); check("sc_st_wait", ready_M, 4'b0000);
        cyc();
        @(negedge clk); check("sc_st_ack", {ready_M, grant_valid, grant_id}, {4'b0001, 1'b1, 2'd0});
        cyc(); set_req(0, c_LD, 10'h013, 8'h00);
        @(negedge clk); check("sc_ld_wait", ready_M, 4'b0000);
        cyc();
        @(negedge clk); check("sc_ld_ack", ready_M, 4'b0001);
        check("sc_ld_data", rd_data_M[7:0], 8'h5A);
        cyc(); set_req(0, c_IDLE, 10'h0, 8'h0);
        @(negedge clk); check("sc_no_third", ready_M, 4'b0000);

        // Preload words used by the contention sections
        for (int c = 0; c < N; c++) do_txn(c, c_ST, 10'h100 + 10'(c), 8'h10 + 8'(c));

        // Contention: all cores hold LD from reset release
        cyc(); reset = 1'b0;
        for (int c = 0; c < N; c++) set_req(c, c_LD, 10'h100 + 10'(c), 8'h0);
        cyc(); reset = 1'b1;
        cyc();
        seq = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("cont_gvalid", grant_valid, 1'b1);
            seq[2*k +: 2] = grant_id;
            cyc();
        end
        check("cont_order", seq, c_CONT_SEQ);
        for (int c = 0; c < N; c++) set_req(c, c_IDLE, 10'h0, 8'h0);
        cyc();

        // Cross-core read-after-write
        set_req(1, c_ST, 10'h2FF, 8'hC3);
        cyc(); set_req(2, c_LD, 10'h2FF, 8'h00);
        @(negedge clk); check("raw_st_ack", ready_M, 4'b0010);
        cyc(); set_req(1, c_IDLE, 10'h0, 8'h0);
        @(negedge clk); check("raw_ld_ack", ready_M, 4'b0100);
        check("raw_data", rd_data_M[23:16], 8'hC3);
        cyc(); set_req(2, c_IDLE, 10'h0, 8'h0);

        // Illegal encoding is idle: no ack, no write
        cyc(); set_req(3, c_BAD, 10'h013, 8'hFF);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); check("bad_idle", {ready_M, grant_valid}, 5'b0);
            cyc();
        end
        set_req(3, c_LD, 10'h013, 8'h00);
        cyc();
        @(negedge clk); check("bad_ld_ack", ready_M, 4'b1000);
        check("bad_nowrite", rd_data_M[31:24], 8'h5A);
        cyc(); set_req(3, c_IDLE, 10'h0, 8'h0);

        // Reset in the cycle a store would be granted
        cyc(); set_req(0, c_ST, 10'h013, 8'hEE); reset = 1'b0;
        cyc(); reset = 1'b1; set_req(0, c_IDLE, 10'h0, 8'h0);
        set_req(1, c_LD, 10'h013, 8'h00);
        @(negedge clk); check("rstop_outputs", {rd_data_M, ready_M, grant_valid, grant_id}, 39'h0);
        cyc();
        @(negedge clk); check("rstop_ack", ready_M, 4'b0010);
        check("rstop_olddata", rd_data_M[15:8], 8'h5A);
        cyc(); set_req(1, c_IDLE, 10'h0, 8'h0);

        // Cores 0 and 2 hold LD: core 0 wins whenever it is unmasked
        cyc(); reset = 1'b0;
        cyc(); reset = 1'b1;
        set_req(0, c_LD, 10'h100, 8'h0);
        set_req(2, c_LD, 10'h102, 8'h0);
        cyc();
        seq4 = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seq4[2*k +: 2] = grant_id;
            cyc();
        end
        check("fp_order", seq4, 8'h88);
        check("fp_data", {rd_data_M[23:16], rd_data_M[7:0]}, 16'h1210);
        set_req(0, c_IDLE, 10'h0, 8'h0);
        set_req(2, c_IDLE, 10'h0, 8'h0);
        repeat (2) cyc();

        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shared data-memory arbiter and storage sitting directly downstream of the cores' M stage. Each core drives `enable_M`, `addr_M` and `wr_data_M` and stalls its whole pipeline until its `ready_M` returns. This block serves at most one LD/ST per cycle from a single shared word array and returns a one-cycle `ready_M` pulse per completed transaction, with read data on `rd_data_M`.

## Interface
- `CORES_NUM`, default 4: number of core ports.
- `REG_SIZE`, default 8: data word width, equal to the core register width.
- `CORE_ID_SIZE`, default 2: bank-select bits prepended by the core.
- `ADDR_SIZE`, default `REG_SIZE+CORE_ID_SIZE`: word address width. Memory depth is 2^`ADDR_SIZE` words.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `enable_M`  in  2*`CORES_NUM`: per-core request. Core i uses bits [2i+1:2i]. 01 = LD, 10 = ST, 00 = idle, 11 = illegal and treated as idle.
- `addr_M`  in  `CORES_NUM`*`ADDR_SIZE`: per-core word address, slice i.
- `wr_data_M`  in  `CORES_NUM`*`REG_SIZE`: per-core store data, slice i.
- `rd_data_M`  out  `CORES_NUM`*`REG_SIZE`: per-core load data, registered.
- `ready_M`  out  `CORES_NUM`: per-core completion pulse, registered.
- `grant_valid`  out  1: a transaction was accepted in the previous cycle (debug/perf).
- `grant_id`  out  `CORE_ID_SIZE`: core index of that transaction.

## Operation
- Core i is eligible in cycle N when its `enable_M` slice is 01 or 10 and `ack_pending[i]`=0. `ack_pending[i]` is the registered version of `ready_M[i]`.
- Exactly one eligible core wins per cycle, chosen by the arbitration policy (see Configuration).
- Winner W, LD: the array is read at `addr_M[W]`. `rd_data_M[W]` is loaded at the end of cycle N.
- Winner W, ST: `wr_data_M[W]` is written to `addr_M[W]` at the end of cycle N.
- Only the winner's bit of `ready_M` is set at the end of cycle N. All other `ready_M` bits are cleared.
- Masking: in cycle N+1 the core still presents the same request, because it advances its pipeline on that edge. `ack_pending` masks core W for cycle N+1, so a request is never double-served. In cycle N+2 core W may present its next LD/ST and be eligible again.
- `rd_data_M` slices hold their value until the next LD served for that core. ST never alters `rd_data_M`.
- Read-after-write: an ST served in cycle N followed by an LD to the same address in cycle N+1 (any core) returns the new data.
- The memory array is not cleared by reset.
- An address outside the depth cannot occur, because the width is exact.

## Timing
- Reset values: `ready_M`=0, `rd_data_M`=0, `grant_valid`=0, `grant_id`=0, `ack_pending`=0, RR pointer=0.
- Reset is applied on the clock edge where `reset`=0, regardless of in-flight state. Any pending ack is dropped, and no ST in the reset cycle is committed.
- Latency: request first visible in cycle N with no contention gives `ready_M` high during cycle N+1. That is 1 stall cycle in the core.
- Per-core peak throughput is one transaction per 2 cycles. Aggregate throughput is 1 per cycle while two or more cores contend.
- `ready_M[i]` is never high for two consecutive cycles.
- `grant_valid`/`grant_id` are asserted in the same cycle as the matching `ready_M`.
- With no eligible requester: no array access, `ready_M`=0, and the RR pointer is unchanged.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - The search starts at the RR pointer and wraps modulo `CORES_NUM`. `CORES_NUM` need not be a power of two.
  - After a grant to W, the pointer becomes (W+1) mod `CORES_NUM`.
- Not defined: fixed priority. The lowest eligible index wins, and the RR pointer logic is omitted.

## Test plan
- Single core: core 0 ST 0x5A to addr 0x013, then LD 0x013. Each `ready_M[0]` is a 1-cycle pulse one cycle after request. `rd_data_M[0]`=0x5A after the LD. No third pulse occurs while enable is held across the ack cycle.
- Contention (RR): cores 0–3 all hold LD continuously from reset release. Grants go 0,1,2,3,0,1,… with `grant_valid`=1 every cycle. Each `ready_M[i]` pulses every 4 cycles.
- Cross-core RAW: core 1 ST 0xC3 to 0x2FF in cycle N; core 2 LD 0x2FF eligible in cycle N+1. `rd_data_M[2]`=0xC3, and core 2 is acked in N+2.
- Illegal/idle: core 3 drives 11 for 10 cycles. No `ready_M[3]`, no write (a later LD of the same address returns the prior value), `grant_valid`=0.
- Reset mid-op: assert `reset`=0 in the cycle core 0's ST is granted. All outputs return to 0, and the address still reads the old data afterwards.
- Fixed priority (macro undefined): cores 0 and 2 hold LD. Grants alternate 0,2,0,2, because core 0 is masked during its ack cycle. If core 0 re-requests in its first eligible cycle together with core 2, core 0 wins that cycle.
